// File: rtl/stopwatch_bcd_source.sv
// stopwatch_bcd_source
//   Two-digit BCD stopwatch count source for a multiplexed seven-segment
//   driver. Two raw buttons are synchronized and debounced. Their rising
//   edges drive a start/pause/clear state machine. A prescaler turns clk
//   into count ticks while running.
//
// Parameters
//   TICK_DIV         clk cycles per count increment while running (>= 2)
//   DEBOUNCE_CYCLES  synchronized cycles a new button level must persist (>= 1)
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous, active-high reset
//   btn_start_stop  raw asynchronous button, active high
//   btn_clear       raw asynchronous button, active high
//   num[7:0]        registered packed BCD {tens, ones}, 00..99
//   running         registered, high while counting
//   wrap            registered one-cycle pulse when the count wraps 99 -> 00
module stopwatch_bcd_source #(
  parameter int unsigned TICK_DIV        = 5000000,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [7:0] num,
  output logic       running,
  output logic       wrap
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  // Button front end: bit BTN_SS is start/stop, bit BTN_CLR is clear.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    level_q, level_d;
  logic [1:0]    level_dly_q, level_dly_d;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];

  // Stopwatch core.
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    num_q, num_d;
  logic          running_q, running_d;
  logic          wrap_q, wrap_d;

  assign btn_raw = {btn_clear, btn_start_stop};

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    level_dly_d = level_q;
    // Press fires the cycle after the debounced level first reads high.
    press_d     = level_q & ~level_dly_q;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    num_d   = num_q;
    wrap_d  = 1'b0;

    if (press_q[BTN_CLR]) begin
      // Clear overrides and swallows a simultaneous start/stop press.
      state_d = S_IDLE;
      presc_d = '0;
      num_d   = 8'h00;
    end else if (press_q[BTN_SS]) begin
      // A press suppresses any tick due on the same edge; pausing freezes
      // the prescaler so a resume finishes the partial interval.
      unique case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          presc_d = '0;
        end
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (num_q[3:0] < 4'd9) begin
          num_d[3:0] = num_q[3:0] + 4'd1;
        end else if (num_q[7:4] < 4'd9) begin
          num_d = {num_q[7:4] + 4'd1, 4'd0};
        end else begin
          num_d  = 8'h00;
          wrap_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    running_d = (state_d == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      // NOTE: the two debounce counters are real control state, not storage,
      // so they are reset explicitly like any other flop.
      deb_cnt_q   <= '{default: '0};
      state_q     <= S_IDLE;
      presc_q     <= '0;
      num_q       <= 8'h00;
      running_q   <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      presc_q     <= presc_d;
      num_q       <= num_d;
      running_q   <= running_d;
      wrap_q      <= wrap_d;
    end
  end

  assign num     = num_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule
